// File: rtl/ocp_multi_monitor.sv
// Multi-channel over-current monitor: per-channel debounce filter, fault latch with
// optional timed auto-retry, saturating trip counters and first-fault capture.
module ocp_multi_monitor #(
    parameter int CH_NUM   = 8,
    parameter int FILT_W   = 4,
    parameter int CNT_W    = 8,
    parameter int CH_IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                    CLK_10MHz,
    input  logic                    RESET,
    input  logic [CH_NUM-1:0]       EN,
    input  logic [CH_NUM-1:0]       OCP_IN,
    input  logic [CH_NUM-1:0]       OCP_CLEAR,
    input  logic [FILT_W-1:0]       FILT_LEN,
    input  logic                    AUTO_RETRY,
    input  logic [15:0]             RETRY_DLY,
    input  logic                    CNT_CLEAR,
    output logic [CH_NUM-1:0]       OCP_RESULT,
    output logic                    OCP_ANY,
    output logic [CH_IDX_W-1:0]     FIRST_CH,
    output logic                    FIRST_VALID,
    output logic [CH_NUM*CNT_W-1:0] TRIP_CNT
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRIPPED = 2'd2} state_t;

    localparam logic [FILT_W-1:0] FILT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [FILT_W:0]       filt_eff;
    logic [16:0]           dly_eff;
    logic [CH_NUM-1:0]     result_vec;
    logic [CH_NUM-1:0]     trip_vec;
    logic [CH_IDX_W-1:0]   first_idx;
    logic [CH_IDX_W-1:0]   first_ch_reg;
    logic                  first_valid_reg;

    // A programmed length or delay of zero behaves as one.
    assign filt_eff = (FILT_LEN == '0) ? (FILT_W+1)'(1) : {1'b0, FILT_LEN};
    assign dly_eff  = (RETRY_DLY == 16'd0) ? 17'd1 : {1'b0, RETRY_DLY};

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            state_t            state_reg, state_next;
            logic [FILT_W-1:0] filt_cnt_reg, filt_cnt_next;
            logic [15:0]       hold_reg, hold_next;
            logic [CNT_W-1:0]  trip_cnt_reg, trip_cnt_next;
            logic              result_reg;
            logic              sample_hit, hold_done, trip;

            assign sample_hit = ({1'b0, filt_cnt_reg} + (FILT_W+1)'(1)) >= filt_eff;
            assign hold_done  = ({1'b0, hold_reg} + 17'd1) >= dly_eff;

            always_ff @(posedge CLK_10MHz) begin
                if (RESET) begin
                    state_reg    <= IDLE;
                    filt_cnt_reg <= '0;
                    hold_reg     <= '0;
                    trip_cnt_reg <= '0;
                    result_reg   <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    filt_cnt_reg <= filt_cnt_next;
                    hold_reg     <= hold_next;
                    trip_cnt_reg <= trip_cnt_next;
                    result_reg   <= (state_next == TRIPPED);
                end
            end

            // Clear beats a trip-completing sample; EN alone never releases a latched trip.
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    IDLE:    if (EN[gi]) state_next = ARMED;
                    ARMED: begin
                        if (!EN[gi])
                            state_next = IDLE;
                        else if (!OCP_CLEAR[gi] && OCP_IN[gi] && sample_hit)
                            state_next = TRIPPED;
                    end
                    TRIPPED: begin
                        if (OCP_CLEAR[gi] || (AUTO_RETRY && hold_done))
                            state_next = EN[gi] ? ARMED : IDLE;
                    end
                    default: state_next = IDLE;
                endcase
            end

            always_comb begin
                trip          = (state_reg == ARMED) && (state_next == TRIPPED);
                filt_cnt_next = '0;
                hold_next     = '0;
                trip_cnt_next = trip_cnt_reg;
                if (state_reg == ARMED && state_next == ARMED && OCP_IN[gi] && !OCP_CLEAR[gi])
                    filt_cnt_next = (filt_cnt_reg == FILT_MAX) ? FILT_MAX : filt_cnt_reg + 1'b1;
                if (state_reg == TRIPPED && state_next == TRIPPED)
                    hold_next = AUTO_RETRY ? hold_reg + 16'd1 : hold_reg;
                if (CNT_CLEAR)
                    trip_cnt_next = trip ? CNT_W'(1) : '0;
                else if (trip && trip_cnt_reg != CNT_MAX)
                    trip_cnt_next = trip_cnt_reg + 1'b1;
            end

            assign result_vec[gi] = result_reg;
            assign trip_vec[gi]   = trip;
            assign TRIP_CNT[gi*CNT_W +: CNT_W] = trip_cnt_reg;
        end
    endgenerate

    always_comb begin
        first_idx = '0;
        for (int i = CH_NUM - 1; i >= 0; i--)
            if (trip_vec[i]) first_idx = CH_IDX_W'(i);
    end

    // A new episode starts only from an all-clear state; capture holds until it ends.
    always_ff @(posedge CLK_10MHz) begin
        if (RESET) begin
            first_ch_reg    <= '0;
            first_valid_reg <= 1'b0;
        end else if (!(|result_vec)) begin
            if (|trip_vec) begin
                first_ch_reg    <= first_idx;
                first_valid_reg <= 1'b1;
            end else begin
                first_valid_reg <= 1'b0;
            end
        end
    end

    assign OCP_RESULT  = result_vec;
    assign OCP_ANY     = |result_vec;
    assign FIRST_CH    = first_ch_reg;
    assign FIRST_VALID = first_valid_reg;
endmodule

// File: tb/tb_ocp_multi_monitor.sv
// Scoreboard bench for ocp_multi_monitor: stimulus queues hand-computed expectations
// stamped with a cycle number; the monitor compares them on the falling edge.
module tb_ocp_multi_monitor;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  en, ocp_in, ocp_clear;
    logic [3:0]  filt_len;
    logic        auto_retry;
    logic [15:0] retry_dly;
    logic        cnt_clear;
    logic [7:0]  ocp_result;
    logic        ocp_any;
    logic [2:0]  first_ch;
    logic        first_valid;
    logic [63:0] trip_cnt;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] res;
        logic       fv;
        logic [2:0] fch;
        int         cnt_ch;
        logic [7:0] cnt;
    } exp_t;
    exp_t sb[$];

    ocp_multi_monitor dut (
        .CLK_10MHz  (clk),
        .RESET      (rst),
        .EN         (en),
        .OCP_IN     (ocp_in),
        .OCP_CLEAR  (ocp_clear),
        .FILT_LEN   (filt_len),
        .AUTO_RETRY (auto_retry),
        .RETRY_DLY  (retry_dly),
        .CNT_CLEAR  (cnt_clear),
        .OCP_RESULT (ocp_result),
        .OCP_ANY    (ocp_any),
        .FIRST_CH   (first_ch),
        .FIRST_VALID(first_valid),
        .TRIP_CNT   (trip_cnt)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // cnt_ch < 0 means the whole TRIP_CNT bus must be zero.
    task automatic chk(input string name, input logic [7:0] res, input logic fv,
                       input logic [2:0] fch, input int cnt_ch, input logic [7:0] cnt);
        exp_t e;
        e.cyc = cyc; e.name = name; e.res = res; e.fv = fv; e.fch = fch;
        e.cnt_ch = cnt_ch; e.cnt = cnt;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic       ok;
        logic [7:0] act_cnt;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            act_cnt = (e.cnt_ch < 0) ? 8'(|trip_cnt) : trip_cnt[e.cnt_ch*8 +: 8];
            ok = (ocp_result == e.res) && (ocp_any == (|e.res)) && (first_valid == e.fv)
                 && (!e.fv || first_ch == e.fch)
                 && ((e.cnt_ch < 0) ? (trip_cnt == 64'd0) : (act_cnt == e.cnt));
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s: got res=%h any=%b fv=%b fch=%0d cnt=%h ; want res=%h any=%b fv=%b fch=%0d cnt[%0d]=%0d",
                         e.name, ocp_result, ocp_any, first_valid, first_ch, trip_cnt,
                         e.res, |e.res, e.fv, e.fch, e.cnt_ch, e.cnt);
            end else begin
                $display("CHECK %s ok res=%h fv=%b fch=%0d", e.name, ocp_result, first_valid, first_ch);
            end
        end
    end

    initial begin
        rst = 1'b1; en = '0; ocp_in = '0; ocp_clear = '0; filt_len = 4'd4;
        auto_retry = 1'b0; retry_dly = 16'd5; cnt_clear = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("reset", 8'h00, 1'b0, 3'd0, -1, 8'd0);

        // Legacy 4-sample filter on ch0
        en[0] = 1'b1; tick(1);
        ocp_in[0] = 1'b1; tick(3);
        chk("filt_3_high", 8'h00, 1'b0, 3'd0, 0, 8'd0);
        ocp_in[0] = 1'b0; tick(1);
        ocp_in[0] = 1'b1; tick(3);
        chk("filt_3_again", 8'h00, 1'b0, 3'd0, 0, 8'd0);
        tick(1);
        chk("filt_4_trip", 8'h01, 1'b1, 3'd0, 0, 8'd1);
        ocp_in[0] = 1'b0; ocp_clear[0] = 1'b1; tick(1);
        chk("clr0_result", 8'h00, 1'b1, 3'd0, 0, 8'd1);
        ocp_clear[0] = 1'b0; tick(1);
        chk("clr0_fv_drop", 8'h00, 1'b0, 3'd0, 0, 8'd1);

        // Latched trip survives EN=0; OCP_CLEAR drops it to IDLE
        en[2] = 1'b1; ocp_in[2] = 1'b1; tick(1);
        tick(4);
        chk("ch2_trip", 8'h04, 1'b1, 3'd2, 2, 8'd1);
        ocp_in[2] = 1'b0; en[2] = 1'b0; tick(2);
        chk("ch2_en_low_hold", 8'h04, 1'b1, 3'd2, 2, 8'd1);
        ocp_clear[2] = 1'b1; tick(1);
        chk("ch2_clear_edge", 8'h00, 1'b1, 3'd2, 2, 8'd1);
        ocp_clear[2] = 1'b0; ocp_in[2] = 1'b1; tick(5);
        chk("ch2_idle", 8'h00, 1'b0, 3'd0, 2, 8'd1);
        ocp_in[2] = 1'b0;

        // Simultaneous trip on ch5/ch3, later ch0
        en[5] = 1'b1; en[3] = 1'b1; tick(1);
        ocp_in[5] = 1'b1; ocp_in[3] = 1'b1; tick(4);
        chk("first_ch3", 8'h28, 1'b1, 3'd3, 3, 8'd1);
        ocp_in[0] = 1'b1; tick(4);
        chk("first_kept", 8'h29, 1'b1, 3'd3, 0, 8'd2);
        ocp_in = '0; ocp_clear = 8'h29; tick(1);
        chk("all_clear", 8'h00, 1'b1, 3'd3, 5, 8'd1);
        ocp_clear = '0; tick(1);
        chk("first_fv_drop", 8'h00, 1'b0, 3'd0, 3, 8'd1);
        en = '0;

        // FILT_LEN=0, clear-wins, CNT_CLEAR coincident with trip
        filt_len = 4'd0; en[4] = 1'b1; tick(1);
        ocp_in[4] = 1'b1; tick(1);
        chk("flen0_trip", 8'h10, 1'b1, 3'd4, 4, 8'd1);
        ocp_in[4] = 1'b0; ocp_clear[4] = 1'b1; tick(1);
        ocp_in[4] = 1'b1; tick(2);
        chk("clear_wins", 8'h00, 1'b0, 3'd0, 4, 8'd1);
        ocp_clear[4] = 1'b0; cnt_clear = 1'b1; tick(1);
        chk("cntclr_trip", 8'h10, 1'b1, 3'd4, 4, 8'd1);
        chk("cntclr_other", 8'h10, 1'b1, 3'd4, 0, 8'd0);
        cnt_clear = 1'b0; ocp_in[4] = 1'b0; ocp_clear[4] = 1'b1; en[4] = 1'b0; tick(1);
        ocp_clear[4] = 1'b0; tick(1);

        // Auto-retry on ch1, RETRY_DLY=5, FILT_LEN=2, saturating count
        auto_retry = 1'b1; retry_dly = 16'd5; filt_len = 4'd2; en[1] = 1'b1; tick(1);
        ocp_in[1] = 1'b1; tick(1);
        chk("ar_sample1", 8'h00, 1'b0, 3'd0, 1, 8'd0);
        tick(1);
        chk("ar_trip_1", 8'h02, 1'b1, 3'd1, 1, 8'd1);
        for (int k = 2; k <= 260; k++) begin
            for (int j = 1; j <= 6; j++) begin
                tick(1);
                if (k <= 3)
                    chk($sformatf("ar_hold_%0d_%0d", k, j), (j <= 4) ? 8'h02 : 8'h00,
                        1'(j <= 5), 3'd1, 1, 8'(k - 1));
            end
            tick(1);
            chk($sformatf("ar_trip_%0d", k), 8'h02, 1'b1, 3'd1, 1, (k > 255) ? 8'd255 : 8'(k));
        end

        // Reset in the middle of a hold-off, then normal re-arm
        tick(2);
        rst = 1'b1; tick(1);
        chk("rst_holdoff", 8'h00, 1'b0, 3'd0, -1, 8'd0);
        rst = 1'b0; tick(2);
        chk("rearm_wait", 8'h00, 1'b0, 3'd0, 1, 8'd0);
        tick(1);
        chk("rearm_trip", 8'h02, 1'b1, 3'd1, 1, 8'd1);

        en = '0; ocp_in = '0; ocp_clear = 8'hFF;
        tick(2);
        for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ocp_multi_monitor.md
# ocp_multi_monitor

Parametrised multi-channel over-current protection monitor; next generation of the single-channel OCP latch used on the OELD power rails. Each channel debounces its comparator input with a run-time-programmable consecutive-sample filter, then latches a fault, optionally auto-retries after a hold-off, and counts trips. A global fault flag and first-fault channel capture feed the power-sequencing FSM and the register interface.

## Interface
- CH_NUM, 8: number of monitored channels, 1..32.
- FILT_W, 4: width of the filter-length field and per-channel sample counter.
- CNT_W, 8: width of each per-channel saturating trip counter.
- CH_IDX_W, $clog2(CH_NUM) (min 1): width of FIRST_CH.

- CLK_10MHz  in  1  sole clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- EN  in  CH_NUM  per-channel monitor enable.
- OCP_IN  in  CH_NUM  per-channel comparator input, pre-synchronised, 1 = over-current.
- OCP_CLEAR  in  CH_NUM  per-channel level clear; held high forces channel to ARMED/IDLE.
- FILT_LEN  in  FILT_W  consecutive high samples needed to trip; 0 treated as 1.
- AUTO_RETRY  in  1  0 = latch until OCP_CLEAR; 1 = release after RETRY_DLY.
- RETRY_DLY  in  16  hold-off cycles in TRIPPED when AUTO_RETRY=1; 0 treated as 1.
- CNT_CLEAR  in  1  synchronous clear of all trip counters.
- OCP_RESULT  out  CH_NUM  registered per-channel fault flag.
- OCP_ANY  out  1  OR of OCP_RESULT (combinational from registers).
- FIRST_CH  out  CH_IDX_W  index of the channel that caused the current fault episode.
- FIRST_VALID  out  1  FIRST_CH is valid.
- TRIP_CNT  out  CH_NUM*CNT_W  per-channel trip counts, channel i at [i*CNT_W +: CNT_W].

## Operation
- Per-channel FSM: IDLE, ARMED, TRIPPED.
- IDLE: counter 0, OCP_RESULT 0. EN=1 -> ARMED.
- ARMED: OCP_IN=1 -> counter+1 (saturates at 2^FILT_W-1); OCP_IN=0 -> counter 0. When the sample taken makes counter+1 >= effective FILT_LEN -> TRIPPED, OCP_RESULT=1, TRIP_CNT+1 (saturating). EN=0 -> IDLE.
- TRIPPED, AUTO_RETRY=0: hold until OCP_CLEAR=1 -> ARMED (EN=1) or IDLE (EN=0), counter 0.
- TRIPPED, AUTO_RETRY=1: hold-off counter loads on entry, release after effective RETRY_DLY cycles -> ARMED/IDLE per EN, OCP_RESULT 0. OCP_CLEAR releases early.
- EN=0 never clears a latched trip.
- OCP_CLEAR=1 in ARMED: counter held 0, no trip. Clear and trip-completing sample on same edge: clear wins, no trip, no count.
- FIRST_CH/FIRST_VALID: on an edge where all OCP_RESULT were 0 and at least one channel trips, capture lowest tripping index, FIRST_VALID=1. Later trips do not overwrite. FIRST_VALID clears on the edge after OCP_ANY returns to 0.
- CNT_CLEAR: all TRIP_CNT to 0. Coincident trip on a channel: that counter loads 1.
- FILT_LEN and RETRY_DLY are sampled every cycle; changes apply to the next comparison.

## Timing
- RESET: all channels IDLE, counters 0, OCP_RESULT 0, OCP_ANY 0, FIRST_CH 0, FIRST_VALID 0, TRIP_CNT 0. RESET mid-trip or mid-hold-off aborts immediately.
- ARMED with OCP_IN high from edge k: OCP_RESULT high after edge k+FILT_LEN-1. FILT_LEN=4 matches the legacy 4-sample filter.
- IDLE->ARMED costs one edge. The first sample counts on the edge after ARMED is entered.
- Auto-retry: OCP_RESULT high for exactly RETRY_DLY cycles.
- OCP_CLEAR in TRIPPED: OCP_RESULT low after the same edge.
- FIRST_CH/FIRST_VALID update on the same edge as OCP_RESULT.

## Test plan
- Reset, EN=1 on ch0, FILT_LEN=4, OCP_IN[0] high 3 cycles then low -> no trip. Then high 4 cycles -> OCP_RESULT[0]=1 after 4th edge, TRIP_CNT[0]=1.
- ch2 latched, EN[2] dropped, then OCP_CLEAR[2] pulsed one cycle -> result stays 1 while EN=0; clears on the clear edge; state IDLE.
- AUTO_RETRY=1, RETRY_DLY=5, OCP_IN[1] stuck high, FILT_LEN=2 -> OCP_RESULT[1] high 5 cycles, low 2 cycles, repeats; TRIP_CNT[1] increments per trip and saturates at 255.
- ch5 and ch3 trip on same edge from all-clear -> FIRST_CH=3, FIRST_VALID=1. ch0 trips later -> FIRST_CH unchanged. Clear all -> FIRST_VALID 0 on following edge.
- FILT_LEN=0 -> trip after 1 high sample. OCP_CLEAR held with completing sample -> no trip. CNT_CLEAR coincident with trip -> count 1.
- RESET asserted during hold-off -> all outputs zero next edge; monitor re-arms normally afterwards.
